// File: rtl/lc3b_regfile_scoreboard_pkg.sv
// Shared LC-3b types used by the register file / scoreboard slice.
//   lc3b_reg   : 3-bit register number
//   lc3b_word  : 16-bit data word
//   lc3b_nzp   : 3-bit condition codes {n,z,p}
//   NZP_RESET  : condition codes after reset (Z set)
//   gen_nzp()  : derive {n,z,p} from a result word
package lc3b_types;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_nzp;

    localparam lc3b_nzp NZP_RESET = 3'b010;

    function automatic lc3b_nzp gen_nzp(input lc3b_word d);
        return {d[15], (d == 16'h0000), (~d[15] & (d != 16'h0000))};
    endfunction
endpackage

// File: rtl/lc3b_regfile_scoreboard_pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : a write to this register was issued
//   dec          : a write to this register is committing
//   clr          : flush; forces the count to zero, overriding inc/dec
//   count        : current number of pending writes
//   is_zero      : count == 0
//   underflow    : combinational pulse, a commit arrived with nothing pending
module lc3b_pend_counter #(
    parameter int MAX_PEND = 3,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          is_zero,
    output logic          underflow
);
    logic [CW-1:0] count_q, count_d;

    // Simultaneous inc and dec cancel; both ends saturate so the count
    // never wraps.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec && (count_q != CW'(MAX_PEND))) begin
            count_d = count_q + CW'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign is_zero   = (count_q == '0);
    assign underflow = dec & ~clr & (count_q == '0);
endmodule

// File: rtl/lc3b_regfile_scoreboard.sv
// LC-3b decode-side register file with writeback bypass and a per-register
// pending-write scoreboard that raises stall on RAW / destination-full hazards.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   sr1/sr2, sr*_used       : decode source registers and whether they are read
//   sr1_data/sr2_data       : read data, bypassed from the writeback bus
//   issue_valid/wr/dr       : decode issue request and its destination
//   stall                   : decode must hold; the issue is not taken
//   wb_valid/dr/data/ld_cc  : stage-5 commit bus
//   nzp                     : condition codes {n,z,p}
//   flush                   : squash stages 3-4, clear the scoreboard
//   err_underflow           : sticky, a commit arrived with nothing pending
module lc3b_regfile_scoreboard
    import lc3b_types::*;
#(
    parameter int MAX_PEND = 3
) (
    input  logic     clk,
    input  logic     reset_n,
    input  lc3b_reg  sr1,
    input  lc3b_reg  sr2,
    input  logic     sr1_used,
    input  logic     sr2_used,
    output lc3b_word sr1_data,
    output lc3b_word sr2_data,
    input  logic     issue_valid,
    input  logic     issue_wr,
    input  lc3b_reg  issue_dr,
    output logic     stall,
    input  logic     wb_valid,
    input  lc3b_reg  wb_dr,
    input  lc3b_word wb_data,
    input  logic     wb_ld_cc,
    output lc3b_nzp  nzp,
    input  logic     flush,
    output logic     err_underflow
);
    localparam int CW = $clog2(MAX_PEND + 1);

    lc3b_word      regs_q [8];
    lc3b_nzp       nzp_q;
    logic          err_q;

    logic [CW-1:0] pend_count [8];
    logic [7:0]    pend_zero;
    logic [7:0]    inc_vec, dec_vec, uf_vec;

    logic byp1, byp2, byp_dr;
    logic haz1, haz2, dfull, take;

    assign byp1   = wb_valid && (wb_dr == sr1);
    assign byp2   = wb_valid && (wb_dr == sr2);
    assign byp_dr = wb_valid && (wb_dr == issue_dr);

    assign sr1_data = byp1 ? wb_data : regs_q[sr1];
    assign sr2_data = byp2 ? wb_data : regs_q[sr2];

    // A source whose only pending write commits this cycle is served by the
    // bypass, so it needs more than one outstanding write to be a hazard.
    assign haz1  = sr1_used & (byp1 ? (pend_count[sr1] > CW'(1)) : ~pend_zero[sr1]);
    assign haz2  = sr2_used & (byp2 ? (pend_count[sr2] > CW'(1)) : ~pend_zero[sr2]);
    // A full destination frees a slot when it commits in the same cycle.
    assign dfull = issue_valid & issue_wr & (pend_count[issue_dr] == CW'(MAX_PEND)) & ~byp_dr;
    assign stall = issue_valid & (haz1 | haz2 | dfull);
    assign take  = issue_valid & issue_wr & ~stall & ~flush;

    for (genvar g = 0; g < 8; g++) begin : g_pend
        assign inc_vec[g] = take && (issue_dr == lc3b_reg'(g));
        assign dec_vec[g] = wb_valid && (wb_dr == lc3b_reg'(g));

        lc3b_pend_counter #(
            .MAX_PEND (MAX_PEND),
            .CW       (CW)
        ) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (inc_vec[g]),
            .dec       (dec_vec[g]),
            .clr       (flush),
            .count     (pend_count[g]),
            .is_zero   (pend_zero[g]),
            .underflow (uf_vec[g])
        );
    end

    // Stage 5 is never squashed, so commits and NZP updates happen even
    // in a flush cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            nzp_q <= NZP_RESET;
            err_q <= 1'b0;
        end else begin
            if (wb_valid) begin
                regs_q[wb_dr] <= wb_data;
            end
            if (wb_valid && wb_ld_cc) begin
                nzp_q <= gen_nzp(wb_data);
            end
            if (|uf_vec) begin
                err_q <= 1'b1;
            end
        end
    end

    assign nzp           = nzp_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_lc3b_regfile_scoreboard.sv
// Directed bench for lc3b_regfile_scoreboard with a behavioural model.
module tb_lc3b_regfile_scoreboard;
    localparam int MAX_PEND = 3;

    logic        clk;
    logic        reset_n;
    logic [2:0]  sr1, sr2;
    logic        sr1_used, sr2_used;
    logic [15:0] sr1_data, sr2_data;
    logic        issue_valid, issue_wr;
    logic [2:0]  issue_dr;
    logic        stall;
    logic        wb_valid;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        wb_ld_cc;
    logic [2:0]  nzp;
    logic        flush;
    logic        err_underflow;

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    lc3b_regfile_scoreboard #(.MAX_PEND(MAX_PEND)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sr1           (sr1),
        .sr2           (sr2),
        .sr1_used      (sr1_used),
        .sr2_used      (sr2_used),
        .sr1_data      (sr1_data),
        .sr2_data      (sr2_data),
        .issue_valid   (issue_valid),
        .issue_wr      (issue_wr),
        .issue_dr      (issue_dr),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_dr         (wb_dr),
        .wb_data       (wb_data),
        .wb_ld_cc      (wb_ld_cc),
        .nzp           (nzp),
        .flush         (flush),
        .err_underflow (err_underflow)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [15:0] m_reg [8];
    int          m_pend [8];
    logic [2:0]  m_nzp;
    logic        m_err;

    function automatic logic [15:0] exp_rd(input logic [2:0] s);
        return (wb_valid && wb_dr == s) ? wb_data : m_reg[s];
    endfunction

    function automatic logic exp_stall();
        logic h1, h2, df;
        h1 = sr1_used && (m_pend[sr1] > ((wb_valid && wb_dr == sr1) ? 1 : 0));
        h2 = sr2_used && (m_pend[sr2] > ((wb_valid && wb_dr == sr2) ? 1 : 0));
        df = issue_valid && issue_wr && (m_pend[issue_dr] == MAX_PEND)
             && !(wb_valid && wb_dr == issue_dr);
        return issue_valid && (h1 || h2 || df);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i]  = 16'h0000;
                m_pend[i] = 0;
            end
            m_nzp = 3'b010;
            m_err = 1'b0;
        end else begin
            logic tk;
            tk = issue_valid && issue_wr && !exp_stall() && !flush;
            if (wb_valid) begin
                if (!flush && m_pend[wb_dr] == 0) m_err = 1'b1;
                m_reg[wb_dr] = wb_data;
                if (wb_ld_cc) begin
                    if (wb_data[15])            m_nzp = 3'b100;
                    else if (wb_data == 16'h0)  m_nzp = 3'b010;
                    else                        m_nzp = 3'b001;
                end
            end
            if (flush) begin
                for (int i = 0; i < 8; i++) m_pend[i] = 0;
            end else begin
                if (tk) m_pend[issue_dr] = m_pend[issue_dr] + 1;
                if (wb_valid && m_pend[wb_dr] > 0) m_pend[wb_dr] = m_pend[wb_dr] - 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_sr1_data", sr1_data, exp_rd(sr1));
            chk("m_sr2_data", sr2_data, exp_rd(sr2));
            chk("m_stall", 16'(stall), 16'(exp_stall()));
            chk("m_nzp", 16'(nzp), 16'(m_nzp));
            chk("m_err", 16'(err_underflow), 16'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        sr1 = 3'd0; sr2 = 3'd0; sr1_used = 1'b0; sr2_used = 1'b0;
        issue_valid = 1'b0; issue_wr = 1'b0; issue_dr = 3'd0;
        wb_valid = 1'b0; wb_dr = 3'd0; wb_data = 16'h0000; wb_ld_cc = 1'b0;
        flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] dr);
        idle();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dr = dr;
    endtask

    task automatic wb(input logic [2:0] dr, input logic [15:0] d, input logic cc);
        wb_valid = 1'b1; wb_dr = dr; wb_data = d; wb_ld_cc = cc;
    endtask

    task automatic probe(input logic [2:0] a, input logic ua, input logic [2:0] b, input logic ub);
        issue_valid = 1'b1; sr1 = a; sr1_used = ua; sr2 = b; sr2_used = ub;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n = 1'b1;
        idle();
        #1 reset_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        probe(3'd3, 1'b1, 3'd6, 1'b1);
        #1;
        chk("rst_sr1", sr1_data, 16'h0000);
        chk("rst_sr2", sr2_data, 16'h0000);
        chk("rst_nzp", 16'(nzp), 16'(3'b010));
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_err", 16'(err_underflow), 16'h0);
        #9 reset_n = 1'b1;
        idle();

        // RAW on R3 resolved by a committing write with bypass
        issue(3'd3);
        #1 chk("r3_issue_stall", 16'(stall), 16'h0);
        tick();
        idle(); probe(3'd3, 1'b1, 3'd0, 1'b0);
        #1 chk("r3_raw_stall", 16'(stall), 16'h1);
        tick();
        wb(3'd3, 16'h8001, 1'b1);
        #1 chk("r3_byp_stall", 16'(stall), 16'h0);
        chk("r3_byp_data", sr1_data, 16'h8001);
        tick();
        idle(); probe(3'd3, 1'b1, 3'd0, 1'b0);
        #1 chk("r3_nzp", 16'(nzp), 16'(3'b100));
        chk("r3_clear_stall", 16'(stall), 16'h0);
        chk("r3_reg_data", sr1_data, 16'h8001);
        tick();

        // Destination full on R5
        for (int i = 0; i < 3; i++) begin
            issue(3'd5);
            #1 chk("r5_fill_stall", 16'(stall), 16'h0);
            tick();
        end
        issue(3'd5);
        #1 chk("r5_full_stall", 16'(stall), 16'h1);
        tick();
        issue(3'd5); wb(3'd5, 16'h0555, 1'b0);
        #1 chk("r5_wb_issue_stall", 16'(stall), 16'h0);
        tick();
        issue(3'd5);
        #1 chk("r5_still_full", 16'(stall), 16'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); wb(3'd5, 16'h0500 + 16'(i), 1'b0);
            tick();
        end
        idle(); probe(3'd5, 1'b1, 3'd5, 1'b1);
        #1 chk("r5_drained_stall", 16'(stall), 16'h0);
        chk("r5_data", sr2_data, 16'h0502);
        tick();

        // Two pending writes on R2
        issue(3'd2); tick();
        issue(3'd2); tick();
        idle(); probe(3'd0, 1'b0, 3'd2, 1'b1); wb(3'd2, 16'h1234, 1'b0);
        #1 chk("r2_first_stall", 16'(stall), 16'h1);
        tick();
        idle(); probe(3'd0, 1'b0, 3'd2, 1'b1); wb(3'd2, 16'h0000, 1'b1);
        #1 chk("r2_second_stall", 16'(stall), 16'h0);
        chk("r2_second_data", sr2_data, 16'h0000);
        tick();
        idle();
        #1 chk("r2_nzp", 16'(nzp), 16'(3'b010));
        tick();

        // Flush alongside a commit to R7
        issue(3'd1); tick();
        issue(3'd4); tick();
        issue(3'd7); tick();
        idle(); flush = 1'b1; wb(3'd7, 16'h7777, 1'b1);
        tick();
        idle(); probe(3'd1, 1'b1, 3'd4, 1'b1);
        #1 chk("flush_stall", 16'(stall), 16'h0);
        chk("flush_err", 16'(err_underflow), 16'h0);
        chk("flush_nzp", 16'(nzp), 16'(3'b001));
        sr1 = 3'd7;
        #1 chk("flush_r7_data", sr1_data, 16'h7777);
        tick();

        // Underflow on R6
        idle(); wb(3'd6, 16'h00C6, 1'b0);
        tick();
        idle(); probe(3'd6, 1'b1, 3'd0, 1'b0);
        #1 chk("uf_r6_data", sr1_data, 16'h00C6);
        chk("uf_err", 16'(err_underflow), 16'h1);
        chk("uf_no_wrap_stall", 16'(stall), 16'h0);
        tick();
        issue(3'd6); tick();
        idle(); probe(3'd6, 1'b1, 3'd0, 1'b0);
        #1 chk("uf_r6_pend_stall", 16'(stall), 16'h1);
        tick();
        idle(); probe(3'd6, 1'b1, 3'd0, 1'b0); wb(3'd6, 16'h0066, 1'b0);
        #1 chk("uf_r6_byp", sr1_data, 16'h0066);
        tick();
        idle();
        #1 chk("uf_sticky", 16'(err_underflow), 16'h1);
        tick();

        // Asynchronous reset mid-run with writes in flight
        issue(3'd0); tick();
        issue(3'd0); tick();
        idle(); probe(3'd6, 1'b1, 3'd0, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_r6", sr1_data, 16'h0000);
        chk("arst_nzp", 16'(nzp), 16'(3'b010));
        chk("arst_err", 16'(err_underflow), 16'h0);
        chk("arst_stall", 16'(stall), 16'h0);
        reset_n = 1'b1;
        tick();
        idle(); probe(3'd0, 1'b1, 3'd3, 1'b1);
        #1 chk("post_rst_stall", 16'(stall), 16'h0);
        chk("post_rst_r3", sr2_data, 16'h0000);
        tick();
        tick();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
